fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 64, width of the pcplus1 field.
REQ-002 Parameter INSTRUCTION_WIDTH, default 32, width of the instruction field.
REQ-003 Parameter DEPTH, default 4, number of entries; a power of two and at least 2.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_enable  input  1  push strobe from fetch, one cycle per fetched instruction.
REQ-007 in_pcplus1  input  ADDRESS_WIDTH  pcplus1 of the pushed instruction.
REQ-008 in_instruction_bits  input  INSTRUCTION_WIDTH  pushed instruction word.
REQ-009 in_decode_enable  input  1  pop request from decode.
REQ-010 in_branch_taken_bool  input  1  flush request from the ALU stage on a taken branch.
REQ-011 out_pcplus1  output  ADDRESS_WIDTH  head-entry pcplus1.
REQ-012 out_instruction_bits  output  INSTRUCTION_WIDTH  head-entry instruction.
REQ-013 out_ready  output  1  head entry valid (queue not empty).
REQ-014 out_full  output  1  backpressure to fetch; count equals DEPTH.
REQ-015 out_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Storage: DEPTH registered entries {pcplus1, instruction_bits}; read pointer, write pointer ($clog2(DEPTH) bits each, natural wrap DEPTH-1 -> 0), occupancy counter.
REQ-017 Head outputs are show-ahead: out_pcplus1 and out_instruction_bits are driven from the entry at the read pointer, with no extra register stage.
REQ-018 When empty: out_ready=0, out_pcplus1=0, out_instruction_bits=0.
REQ-019 Pop fires when in_decode_enable=1 and out_ready=1; the read pointer advances at the next edge; a pop request while empty is ignored.
REQ-020 Push fires when in_enable=1 and (out_full=0 or a pop fires in the same cycle); the entry is written at the write pointer, which then advances.
REQ-021 A push while full with no pop is dropped; state is unchanged.
REQ-022 A simultaneous push and pop leaves out_count unchanged; both pointers advance.
REQ-023 Latency: an instruction pushed into an empty queue at edge N appears on the head outputs with out_ready=1 in the cycle after edge N; there is no same-cycle bypass.
REQ-024 Flush has highest priority: in_branch_taken_bool=1 sets count=0 and read pointer = write pointer = 0 at the next edge; any same-cycle push or pop is discarded.
REQ-025 out_full and out_ready are derived from the occupancy counter only; the counter never exceeds DEPTH and never underflows.
REQ-026 Entry contents are not cleared on pop or flush; only the pointers and counter change.

Reset
REQ-027 When reset=1 at a rising edge: count, read pointer and write pointer become 0, giving out_ready=0, out_full=0, out_count=0 and zero head data.
REQ-028 Reset overrides flush, push and pop in the same cycle.
REQ-029 Reset asserted mid-operation discards all queued entries.

Structure
REQ-030 The entry struct type fetch_entry_t {pcplus1, instruction_bits} belongs in the shared pipeline package, so that fetch and decode can reuse it.
REQ-031 The block is a single module with no sub-module; storage is a register array, not a memory macro.

Verification
REQ-032 Push then drain (DEPTH=4): push pcplus1 0x1004/0x1008/0x100C with instructions 0x00000013/0x00100093/0x00200113 on consecutive cycles, then pop three times -> head shows them in order, out_count 1,2,3,2,1,0, out_ready=0 at end.
REQ-033 Full boundary: push 5 entries with no pop -> out_full=1 after the 4th, the 5th is dropped, out_count=4, drain yields the first 4 only.
REQ-034 Full plus simultaneous push and pop: with the queue full, push 0x2000 while popping -> the push is accepted, out_count stays 4, and 0x2000 is the last entry drained.
REQ-035 Flush priority: with 3 entries queued, assert in_branch_taken_bool together with in_enable and in_decode_enable -> next cycle out_count=0 and out_ready=0; a later push of 0x3000 appears at the head one cycle after it is pushed.
REQ-036 Wrap-around: run 10 push/pop pairs with pcplus1 incrementing by 4 -> the FIFO order is preserved across pointer wrap and out_count never exceeds 1.
REQ-037 Reset mid-operation: with 2 entries queued, assert reset together with a push -> next cycle all outputs are 0 and the push is discarded.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared pipeline types for the fetch/decode boundary
// Holds the queued instruction entry so fetch and decode agree on its layout.
package fetch_queue_pkg;

  localparam int FQ_ADDRESS_WIDTH     = 64;
  localparam int FQ_INSTRUCTION_WIDTH = 32;

  typedef struct packed {
    logic [FQ_ADDRESS_WIDTH-1:0]     pcplus1;
    logic [FQ_INSTRUCTION_WIDTH-1:0] instruction_bits;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - show-ahead instruction queue between fetch and decode
// A taken branch flushes all entries; reset overrides flush, push and pop.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = FQ_ADDRESS_WIDTH,
  parameter int INSTRUCTION_WIDTH = FQ_INSTRUCTION_WIDTH,
  parameter int DEPTH             = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_enable,
  input  logic [ADDRESS_WIDTH-1:0]     in_pcplus1,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits,
  input  logic                         in_decode_enable,
  input  logic                         in_branch_taken_bool,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus1,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits,
  output logic                         out_ready,
  output logic                         out_full,
  output logic [$clog2(DEPTH):0]       out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   r_entries [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  logic           w_ready;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_write;
  fetch_entry_t   w_new_entry;
  fetch_entry_t   w_head;

  assign w_ready = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = in_decode_enable & w_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push  = in_enable & (~w_full | w_pop);
  assign w_write = w_push & ~reset & ~in_branch_taken_bool;

  assign w_new_entry.pcplus1          = FQ_ADDRESS_WIDTH'(in_pcplus1);
  assign w_new_entry.instruction_bits = FQ_INSTRUCTION_WIDTH'(in_instruction_bits);

  always_ff @(posedge clk) begin
    if (reset || in_branch_taken_bool) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Entry storage is never cleared; only the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_entries[r_wr_ptr] <= w_new_entry;
    end
  end

  assign w_head = r_entries[r_rd_ptr];

  assign out_ready            = w_ready;
  assign out_full             = w_full;
  assign out_count            = r_count;
  assign out_pcplus1          = w_ready ? ADDRESS_WIDTH'(w_head.pcplus1) : '0;
  assign out_instruction_bits = w_ready ? INSTRUCTION_WIDTH'(w_head.instruction_bits) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        in_enable;
  logic [63:0] in_pcplus1;
  logic [31:0] in_instruction_bits;
  logic        in_decode_enable;
  logic        in_branch_taken_bool;
  logic [63:0] out_pcplus1;
  logic [31:0] out_instruction_bits;
  logic        out_ready;
  logic        out_full;
  logic [2:0]  out_count;

  int n_checks;
  int n_fails;

  fetch_queue #(.ADDRESS_WIDTH(64), .INSTRUCTION_WIDTH(32), .DEPTH(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .in_enable            (in_enable),
    .in_pcplus1           (in_pcplus1),
    .in_instruction_bits  (in_instruction_bits),
    .in_decode_enable     (in_decode_enable),
    .in_branch_taken_bool (in_branch_taken_bool),
    .out_pcplus1          (out_pcplus1),
    .out_instruction_bits (out_instruction_bits),
    .out_ready            (out_ready),
    .out_full             (out_full),
    .out_count            (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1ns after the edge.
  task automatic cycle(input logic en, input logic [63:0] pc, input logic [31:0] ins,
                       input logic pop, input logic flush);
    in_enable            = en;
    in_pcplus1           = pc;
    in_instruction_bits  = ins;
    in_decode_enable     = pop;
    in_branch_taken_bool = flush;
    @(posedge clk);
    #1;
    in_enable            = 1'b0;
    in_decode_enable     = 1'b0;
    in_branch_taken_bool = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".count"}, 64'(out_count), 64'd0);
    check({tag, ".ready"}, 64'(out_ready), 64'd0);
    check({tag, ".full"},  64'(out_full), 64'd0);
    check({tag, ".pc"},    out_pcplus1, 64'd0);
    check({tag, ".ins"},   64'(out_instruction_bits), 64'd0);
  endtask

  logic [63:0] pc_tab  [3];
  logic [31:0] ins_tab [3];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    in_enable = 1'b0;
    in_pcplus1 = '0;
    in_instruction_bits = '0;
    in_decode_enable = 1'b0;
    in_branch_taken_bool = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_empty("reset");

    // Push three, then drain three.
    pc_tab  = '{64'h1004, 64'h1008, 64'h100C};
    ins_tab = '{32'h00000013, 32'h00100093, 32'h00200113};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pc_tab[i], ins_tab[i], 1'b0, 1'b0);
      check($sformatf("fill%0d.count", i), 64'(out_count), 64'(i + 1));
      check($sformatf("fill%0d.pc", i), out_pcplus1, 64'h1004);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain%0d.pc", i), out_pcplus1, pc_tab[i]);
      check($sformatf("drain%0d.ins", i), 64'(out_instruction_bits), 64'(ins_tab[i]));
      check($sformatf("drain%0d.ready", i), 64'(out_ready), 64'd1);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      check($sformatf("drain%0d.count", i), 64'(out_count), 64'(2 - i));
    end
    check_empty("drained");

    // Full boundary: fifth push is dropped.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 64'hA000 + 64'(4 * i), 32'(i), 1'b0, 1'b0);
      check($sformatf("full%0d.count", i), 64'(out_count), 64'((i < 4) ? i + 1 : 4));
      check($sformatf("full%0d.full", i), 64'(out_full), 64'((i >= 3) ? 1 : 0));
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fdrain%0d.pc", i), out_pcplus1, 64'hA000 + 64'(4 * i));
      check($sformatf("fdrain%0d.ins", i), 64'(out_instruction_bits), 64'(i));
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    check_empty("fdrained");

    // Full plus simultaneous push and pop.
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'hB000 + 64'(4 * i), 32'hB0 + 32'(i), 1'b0, 1'b0);
    check("fp.full", 64'(out_full), 64'd1);
    cycle(1'b1, 64'h2000, 32'h2000, 1'b1, 1'b0);
    check("fp.count", 64'(out_count), 64'd4);
    check("fp.full2", 64'(out_full), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fpdrain%0d.pc", i), out_pcplus1, (i < 3) ? 64'hB004 + 64'(4 * i) : 64'h2000);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
    end
    check_empty("fpdrained");

    // Flush beats same-cycle push and pop.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'hF000 + 64'(4 * i), 32'hF0, 1'b0, 1'b0);
    check("fl.count3", 64'(out_count), 64'd3);
    cycle(1'b1, 64'hF100, 32'hF1, 1'b1, 1'b1);
    check_empty("flush");
    cycle(1'b1, 64'h3000, 32'h3000, 1'b0, 1'b0);
    check("fl.pc", out_pcplus1, 64'h3000);
    check("fl.ready", 64'(out_ready), 64'd1);
    check("fl.count", 64'(out_count), 64'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check("fl.drained", 64'(out_count), 64'd0);

    // Wrap-around with paired push/pop.
    cycle(1'b1, 64'hC000, 32'hC0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      check($sformatf("wrap%0d.pc", i), out_pcplus1, 64'hC000 + 64'(4 * (i - 1)));
      cycle(1'b1, 64'hC000 + 64'(4 * i), 32'hC0 + 32'(i), 1'b1, 1'b0);
      check($sformatf("wrap%0d.count", i), 64'(out_count), 64'd1);
    end
    check("wrap.last.pc", out_pcplus1, 64'hC024);
    check("wrap.last.ins", 64'(out_instruction_bits), 64'hC9);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check_empty("wrapped");

    // Reset mid-operation discards entries and the same-cycle push.
    cycle(1'b1, 64'hD000, 32'hD0, 1'b0, 1'b0);
    cycle(1'b1, 64'hD004, 32'hD4, 1'b0, 1'b0);
    check("rst.count2", 64'(out_count), 64'd2);
    reset = 1'b1;
    cycle(1'b1, 64'hD008, 32'hD8, 1'b0, 1'b0);
    reset = 1'b0;
    check_empty("midreset");
    cycle(1'b1, 64'hE000, 32'hE0, 1'b0, 1'b0);
    check("rst.pc", out_pcplus1, 64'hE000);
    check("rst.count1", 64'(out_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
